// File: rtl/hps_handshake_pkg.sv
// rtl/hps_handshake_pkg.sv - shared constants and state type for the HPS handshake responder
package hps_handshake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_QUAL = 3'd1,
        ST_CMD  = 3'd2,
        ST_RESP = 3'd3,
        ST_ACK  = 3'd4
    } hs_state_t;

    localparam int REQ_BIT = 16;
    localparam int ACK_BIT = 16;
    localparam logic [15:0] TIMEOUT_CODE = 16'hDEAD;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/hps_handshake_sync.sv
// rtl/hps_handshake_sync.sv - two-flop synchronizer for the HPS PIO output bus
module hps_handshake_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;

    // Two back-to-back flops; only the second stage is used downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage1 <= '0;
            stage2 <= '0;
        end else begin
            stage1 <= d;
            stage2 <= stage1;
        end
    end

    assign q = stage2;

endmodule

// File: rtl/hps_handshake_responder.sv
// rtl/hps_handshake_responder.sv - 4-phase HPS PIO handshake bridged to a command/response fabric port
module hps_handshake_responder
    import hps_handshake_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH:0]   hs_out_port,
    output logic [DATA_WIDTH:0]   hs_in_port,
    output logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    output logic                  busy,
    output logic                  abort_pulse,
    output logic                  timeout_err
);

    // Timer counts 0 .. TIMEOUT_CYCLES-1; the expiry fires on the cycle it sits at the last value.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [DATA_WIDTH:0]   sync_q;
    logic                  req_s;
    logic [DATA_WIDTH-1:0] data_s;
    hs_state_t             state;
    logic [TW-1:0]         timer;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rsp_word;
    logic                  timeout_hit;

    hps_handshake_sync #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (hs_out_port),
        .q     (sync_q)
    );

    assign req_s       = sync_q[DATA_WIDTH];
    assign data_s      = sync_q[DATA_WIDTH-1:0];
    assign timeout_hit = TIMEOUT_EN && (timer == TIMER_LAST);
    assign hs_in_port  = {ack, rsp_word};

    // Handshake FSM; every output is a flop updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            cmd_data    <= '0;
            cmd_valid   <= 1'b0;
            rsp_ready   <= 1'b0;
            busy        <= 1'b0;
            abort_pulse <= 1'b0;
            timeout_err <= 1'b0;
            ack         <= 1'b0;
            rsp_word    <= '0;
        end else begin
            abort_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_s) begin
                        state <= ST_QUAL;
                        busy  <= 1'b1;
                    end
                end
                ST_QUAL: begin
                    // A req that does not survive one more cycle is a glitch, not an abort.
                    if (req_s) begin
                        cmd_data    <= data_s;
                        cmd_valid   <= 1'b1;
                        timeout_err <= 1'b0;
                        timer       <= '0;
                        state       <= ST_CMD;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (!req_s) begin
                        abort_pulse <= 1'b1;
                        cmd_valid   <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                        timer     <= timer + TW'(1);
                        state     <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_word    <= DATA_WIDTH'(TIMEOUT_CODE);
                        ack         <= 1'b1;
                        timeout_err <= 1'b1;
                        cmd_valid   <= 1'b0;
                        state       <= ST_ACK;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (!req_s) begin
                        abort_pulse <= 1'b1;
                        rsp_ready   <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (rsp_valid) begin
                        rsp_word  <= rsp_data;
                        ack       <= 1'b1;
                        rsp_ready <= 1'b0;
                        state     <= ST_ACK;
                    end else if (timeout_hit) begin
                        rsp_word    <= DATA_WIDTH'(TIMEOUT_CODE);
                        ack         <= 1'b1;
                        timeout_err <= 1'b1;
                        rsp_ready   <= 1'b0;
                        state       <= ST_ACK;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_ACK: begin
                    // Response word is left in place after ack drops.
                    if (!req_s) begin
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/hps_handshake_responder.md
HPS_HANDSHAKE_RESPONDER -- requirements
Module: hps_handshake_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the command and response words; hs port width is DATA_WIDTH+1.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: number of cycles allowed in CMD+RESP before forced timeout; 0 disables the timeout.
REQ-003 Port clk  input  1: single clock; all logic is rising-edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port hs_out_port  input  17: from HPS PIO out_port; [16] = req, [15:0] = command word.
REQ-006 Port hs_in_port  output  17: to HPS PIO in_port; [16] = ack, [15:0] = response word.
REQ-007 Port cmd_data  output  16: captured command word toward the fabric.
REQ-008 Port cmd_valid / cmd_ready  output / input  1 each: command handshake; transfer occurs on a cycle with both high.
REQ-009 Port rsp_data / rsp_valid  input  16 / 1: fabric response word and qualifier.
REQ-010 Port rsp_ready  output  1: high only in state RESP.
REQ-011 Port busy  output  1: high whenever state is not IDLE.
REQ-012 Port abort_pulse  output  1: one-cycle pulse when HPS withdraws req mid-transaction.
REQ-013 Port timeout_err  output  1: sticky flag; set on timeout, cleared when the next command is captured.

Function
REQ-014 hs_out_port SHALL pass through a 2-stage synchronizer; req_s and data_s denote the stage-2 outputs.
REQ-015 The protocol is a 4-phase level handshake: req up, ack up, req down, ack down.
REQ-016 States: IDLE, QUAL, CMD, RESP, ACK; all outputs are registered.
REQ-017 IDLE: req_s=1 -> QUAL.
REQ-018 QUAL: req_s=1 -> capture data_s into cmd_data, clear timeout_err, clear timer, go to CMD; req_s=0 -> IDLE with no abort_pulse.
REQ-019 cmd_valid SHALL be first high 4 cycles after hs_out_port[16] rises (2 sync, IDLE->QUAL, QUAL->CMD).
REQ-020 CMD: cmd_valid=1 and cmd_data held stable; cmd_ready=1 -> RESP with cmd_valid low the next cycle.
REQ-021 RESP: rsp_ready=1; rsp_valid=1 -> latch rsp_data into hs_in_port[15:0] and go to ACK.
REQ-022 ACK: hs_in_port[16]=1; req_s=0 -> IDLE with hs_in_port[16]=0 the next cycle.
REQ-023 hs_in_port[15:0] SHALL hold the last response until a new response or timeout code is written; it is never cleared outside reset.
REQ-024 The timer increments each cycle in CMD and RESP. When it reaches TIMEOUT_CYCLES (nonzero): hs_in_port[15:0] = 16'hDEAD, timeout_err=1, cmd_valid=0, go to ACK.
REQ-025 Abort: req_s=0 in CMD or RESP -> IDLE, abort_pulse=1 for one cycle, cmd_valid=0, ack stays 0, hs_in_port[15:0] unchanged.
REQ-026 Priority in the same cycle is abort > rsp_valid > timeout; likewise abort > cmd_ready > timeout.
REQ-027 rsp_valid outside RESP and cmd_ready outside CMD SHALL be ignored.
REQ-028 A new req while in ACK SHALL be impossible by protocol; a req held high in ACK simply holds ACK.

Reset
REQ-029 On reset=1 at a clk edge: state=IDLE; synchronizer flops, timer, and cmd_data = 0; hs_in_port=17'h0; cmd_valid, rsp_ready, busy, abort_pulse, timeout_err = 0.
REQ-030 Reset asserted mid-transaction SHALL abandon it with no abort_pulse; the HPS observes ack=0 and data=0.

Structure
REQ-031 Package hps_handshake_pkg SHALL hold: the state enum, REQ_BIT/ACK_BIT=16, TIMEOUT_CODE=16'hDEAD, and the default TIMEOUT_CYCLES.
REQ-032 Sub-module hps_handshake_sync (parameterised width, 2-flop synchronizer, synchronous reset) SHALL be instantiated once for hs_out_port.

Verification
REQ-033 Normal transaction:
- hs_out_port=17'h1_1234 at cycle 0 -> cmd_valid=1 and cmd_data=16'h1234 at cycle 4.
- cmd_ready pulse, then rsp_valid with rsp_data=16'hBEEF -> hs_in_port=17'h1_BEEF.
- Drop req -> hs_in_port[16]=0 three cycles later.
REQ-034 Glitch: req high for 1 cycle only -> state returns to IDLE, no cmd_valid, no abort_pulse.
REQ-035 Abort: drop req while in RESP -> abort_pulse for exactly 1 cycle, busy=0, hs_in_port unchanged, ack never rises.
REQ-036 Timeout: TIMEOUT_CYCLES=8, cmd_ready held 0 -> after 8 cycles in CMD, hs_in_port=17'h1_DEAD and timeout_err=1; next command capture clears timeout_err.
REQ-037 Simultaneous events: rsp_valid=1 on the same cycle req_s falls -> abort wins, response discarded. rsp_valid on the timeout cycle -> response wins, timeout_err stays 0.
REQ-038 Reset mid-CMD -> all outputs 0 the next cycle; the following transaction completes normally.
